// File: rtl/lsu_nbload_cam.sv
// Outstanding non-blocking load tracker: tag allocation, RAW source CAM, WAW/flush write-back kill.
// Optional macro RV_NBLOAD_CAM_BYPASS_EN masks the source hit while the returning data can be forwarded.
module lsu_nbload_cam #(
  parameter int DEPTH = 4,
  parameter int TAGW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            alloc_valid,
  input  logic [4:0]      alloc_rd,
  output logic            alloc_ready,
  output logic [TAGW-1:0] alloc_tag,
  input  logic            wb_valid,
  input  logic [TAGW-1:0] wb_tag,
  input  logic            wb_error,
  input  logic            flush,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_hit,
  output logic            rs2_hit,
  output logic            wb_rd_valid,
  output logic [4:0]      wb_rd,
  output logic [TAGW:0]   count
);

  typedef struct packed {
    logic       valid;
    logic       wb;
    logic [4:0] rd;
  } load_cam_pkt_t;

  load_cam_pkt_t [DEPTH-1:0] ent;

  logic             alloc_fire;
  logic             wb_fire;
  logic             wb_write;
  logic [DEPTH-1:0] hv1;
  logic [DEPTH-1:0] hv2;
  logic [DEPTH-1:0] wb_onehot;
  logic             free_found;
  logic             hit1_raw;
  logic             hit2_raw;

  // Free-slot priority encoder: lowest-index invalid entry.
  always_comb begin
    alloc_tag  = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent[i].valid && !free_found) begin
        alloc_tag  = TAGW'(i);
        free_found = 1'b1;
      end
    end
  end

  // Allocation handshake: a load is accepted only in a cycle where alloc_valid && alloc_ready;
  // alloc_valid while alloc_ready=0 is dropped, not held, so the issuer must retry.
  assign alloc_ready = free_found;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign wb_fire     = wb_valid & ent[wb_tag].valid;
  assign wb_write    = wb_fire & ent[wb_tag].wb & ~wb_error & ~flush;
  assign wb_onehot   = DEPTH'(1) << wb_tag;

  always_comb begin
    hv1 = '0;
    hv2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hv1[i] = ent[i].valid & ent[i].wb & (ent[i].rd == rs1);
      hv2[i] = ent[i].valid & ent[i].wb & (ent[i].rd == rs2);
    end
  end

  assign hit1_raw = (rs1 != 5'd0) & (|hv1);
  assign hit2_raw = (rs2 != 5'd0) & (|hv2);

`ifdef RV_NBLOAD_CAM_BYPASS_EN
  // Data returning this cycle is forwarded, so a hit solely on that entry needs no stall.
  assign rs1_hit = hit1_raw & ~(wb_write & hv1[wb_tag] & ~(|(hv1 & ~wb_onehot)));
  assign rs2_hit = hit2_raw & ~(wb_write & hv2[wb_tag] & ~(|(hv2 & ~wb_onehot)));
`else
  assign rs1_hit = hit1_raw;
  assign rs2_hit = hit2_raw;
`endif

  // The freed entry is always valid and the allocated one always invalid, so branches never collide.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ent <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_fire && wb_tag == TAGW'(i)) begin
          ent[i].valid <= 1'b0;
          ent[i].wb    <= 1'b0;
        end else if (alloc_fire && alloc_tag == TAGW'(i)) begin
          ent[i].valid <= 1'b1;
          ent[i].wb    <= (alloc_rd != 5'd0);
          ent[i].rd    <= alloc_rd;
        end else if (ent[i].valid && (flush || (alloc_fire && ent[i].rd == alloc_rd))) begin
          ent[i].wb <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wb_rd_valid <= 1'b0;
      wb_rd       <= 5'd0;
      count       <= '0;
    end else begin
      wb_rd_valid <= wb_write;
      wb_rd       <= wb_write ? ent[wb_tag].rd : 5'd0;
      count       <= count + (TAGW+1)'(alloc_fire) - (TAGW+1)'(wb_fire);
    end
  end

endmodule

// File: tb/tb_lsu_nbload_cam.sv
// Directed bench for lsu_nbload_cam (DEPTH=4); expectations are hand-computed per scenario.
module tb_lsu_nbload_cam;

  localparam int DEPTH = 4;
  localparam int TAGW  = 2;

  logic            clk;
  logic            rst_l;
  logic            alloc_valid;
  logic [4:0]      alloc_rd;
  logic            alloc_ready;
  logic [TAGW-1:0] alloc_tag;
  logic            wb_valid;
  logic [TAGW-1:0] wb_tag;
  logic            wb_error;
  logic            flush;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            wb_rd_valid;
  logic [4:0]      wb_rd;
  logic [TAGW:0]   count;

  int total = 0;
  int bad   = 0;

  lsu_nbload_cam #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_l(rst_l),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_error(wb_error), .flush(flush),
    .rs1(rs1), .rs2(rs2), .rs1_hit(rs1_hit), .rs2_hit(rs2_hit),
    .wb_rd_valid(wb_rd_valid), .wb_rd(wb_rd), .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one active edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_rd = 0; wb_valid = 0; wb_tag = 0;
    wb_error = 0; flush = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic do_alloc(input logic [4:0] rd);
    alloc_valid = 1; alloc_rd = rd;
    step();
    alloc_valid = 0; alloc_rd = 0;
  endtask

  task automatic do_return(input logic [TAGW-1:0] tag);
    wb_valid = 1; wb_tag = tag;
    step();
    wb_valid = 0; wb_tag = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH; i++) do_return(TAGW'(i));
    step();
  endtask

  task automatic test_reset();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count act=%0d exp=0", count); end
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready act=%b exp=1", alloc_ready); end
    total++; if (alloc_tag !== 2'd0) begin bad++; $display("FAIL reset_tag act=%0d exp=0", alloc_tag); end
    total++; if (wb_rd_valid !== 1'b0 || wb_rd !== 5'd0) begin bad++; $display("FAIL reset_wb act=%b/%0d exp=0/0", wb_rd_valid, wb_rd); end
  endtask

  task automatic test_basic();
    alloc_valid = 1; alloc_rd = 5; #1;
    total++; if (alloc_tag !== 2'd0) begin bad++; $display("FAIL basic_tag0 act=%0d exp=0", alloc_tag); end
    step(); alloc_rd = 6; #1;
    total++; if (alloc_tag !== 2'd1) begin bad++; $display("FAIL basic_tag1 act=%0d exp=1", alloc_tag); end
    step(); alloc_rd = 7; #1;
    total++; if (alloc_tag !== 2'd2) begin bad++; $display("FAIL basic_tag2 act=%0d exp=2", alloc_tag); end
    step(); alloc_valid = 0; rs1 = 6; rs2 = 7; #1;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL basic_count act=%0d exp=3", count); end
    total++; if (rs1_hit !== 1'b1 || rs2_hit !== 1'b1) begin bad++; $display("FAIL basic_hit act=%b%b exp=11", rs1_hit, rs2_hit); end
    do_return(2'd1);
    total++; if (wb_rd_valid !== 1'b1 || wb_rd !== 5'd6) begin bad++; $display("FAIL basic_wb act=%b/%0d exp=1/6", wb_rd_valid, wb_rd); end
    total++; if (rs1_hit !== 1'b0) begin bad++; $display("FAIL basic_hit_clr act=%b exp=0", rs1_hit); end
    total++; if (count !== 3'd2) begin bad++; $display("FAIL basic_count2 act=%0d exp=2", count); end
    step();
    total++; if (wb_rd_valid !== 1'b0) begin bad++; $display("FAIL basic_wb_pulse act=%b exp=0", wb_rd_valid); end
    rs1 = 0; rs2 = 0;
    drain();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL basic_drain act=%0d exp=0", count); end
  endtask

  task automatic test_full();
    for (int i = 1; i <= DEPTH; i++) do_alloc(5'(i));
    total++; if (alloc_ready !== 1'b0 || count !== 3'd4) begin bad++; $display("FAIL full_state act=%b/%0d exp=0/4", alloc_ready, count); end
    do_alloc(5'd8);
    rs1 = 8; #1;
    total++; if (count !== 3'd4 || rs1_hit !== 1'b0) begin bad++; $display("FAIL full_ignore act=%0d/%b exp=4/0", count, rs1_hit); end
    wb_valid = 1; wb_tag = 2; alloc_valid = 1; alloc_rd = 8; #1;
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_wb_ready act=%b exp=0", alloc_ready); end
    step(); wb_valid = 0; #1;
    total++; if (alloc_ready !== 1'b1 || alloc_tag !== 2'd2 || count !== 3'd3) begin bad++; $display("FAIL full_freed act=%b/%0d/%0d exp=1/2/3", alloc_ready, alloc_tag, count); end
    step(); alloc_valid = 0; #1;
    total++; if (count !== 3'd4 || rs1_hit !== 1'b1) begin bad++; $display("FAIL full_realloc act=%0d/%b exp=4/1", count, rs1_hit); end
    rs1 = 0;
    drain();
  endtask

  task automatic test_waw();
    do_alloc(5'd9);
    do_alloc(5'd9);
    do_return(2'd0);
    rs1 = 9; #1;
    total++; if (wb_rd_valid !== 1'b0) begin bad++; $display("FAIL waw_old act=%b exp=0", wb_rd_valid); end
    total++; if (rs1_hit !== 1'b1) begin bad++; $display("FAIL waw_young_hit act=%b exp=1", rs1_hit); end
    do_return(2'd1);
    total++; if (wb_rd_valid !== 1'b1 || wb_rd !== 5'd9) begin bad++; $display("FAIL waw_young act=%b/%0d exp=1/9", wb_rd_valid, wb_rd); end
    // older rd 10 returns while a younger rd 10 allocates
    do_alloc(5'd10);
    alloc_valid = 1; alloc_rd = 10; wb_valid = 1; wb_tag = 0;
    step(); alloc_valid = 0; wb_valid = 0; rs1 = 10; #1;
    total++; if (wb_rd_valid !== 1'b1 || wb_rd !== 5'd10) begin bad++; $display("FAIL waw_same_cyc act=%b/%0d exp=1/10", wb_rd_valid, wb_rd); end
    total++; if (rs1_hit !== 1'b1 || count !== 3'd1) begin bad++; $display("FAIL waw_same_keep act=%b/%0d exp=1/1", rs1_hit, count); end
    do_return(2'd1);
    total++; if (wb_rd_valid !== 1'b1 || wb_rd !== 5'd10) begin bad++; $display("FAIL waw_same_young act=%b/%0d exp=1/10", wb_rd_valid, wb_rd); end
    rs1 = 0;
    step();
  endtask

  task automatic test_flush();
    do_alloc(5'd11);
    do_alloc(5'd12);
    flush = 1; step(); flush = 0;
    rs1 = 11; rs2 = 12; #1;
    total++; if (rs1_hit !== 1'b0 || rs2_hit !== 1'b0 || count !== 3'd2) begin bad++; $display("FAIL flush_hits act=%b%b/%0d exp=00/2", rs1_hit, rs2_hit, count); end
    do_return(2'd0);
    total++; if (wb_rd_valid !== 1'b0 || count !== 3'd1) begin bad++; $display("FAIL flush_ret0 act=%b/%0d exp=0/1", wb_rd_valid, count); end
    do_return(2'd1);
    total++; if (wb_rd_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL flush_ret1 act=%b/%0d exp=0/0", wb_rd_valid, count); end
    alloc_valid = 1; alloc_rd = 13; flush = 1;
    step(); alloc_valid = 0; flush = 0; rs1 = 13; #1;
    total++; if (rs1_hit !== 1'b1) begin bad++; $display("FAIL flush_alloc_kept act=%b exp=1", rs1_hit); end
    wb_valid = 1; wb_tag = 0; flush = 1;
    step(); wb_valid = 0; flush = 0; #1;
    total++; if (wb_rd_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL flush_with_wb act=%b/%0d exp=0/0", wb_rd_valid, count); end
    rs1 = 0; rs2 = 0;
    step();
  endtask

  task automatic test_rd0_error();
    do_alloc(5'd0);
    rs1 = 0; #1;
    total++; if (count !== 3'd1 || rs1_hit !== 1'b0) begin bad++; $display("FAIL rd0_state act=%0d/%b exp=1/0", count, rs1_hit); end
    do_return(2'd0);
    total++; if (wb_rd_valid !== 1'b0) begin bad++; $display("FAIL rd0_nowb act=%b exp=0", wb_rd_valid); end
    do_alloc(5'd3);
    rs1 = 3; #1;
    total++; if (rs1_hit !== 1'b1) begin bad++; $display("FAIL err_hit act=%b exp=1", rs1_hit); end
    wb_error = 1; do_return(2'd0); wb_error = 0;
    total++; if (wb_rd_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL err_free act=%b/%0d exp=0/0", wb_rd_valid, count); end
    rs1 = 0;
    step();
  endtask

  task automatic test_bypass_reset();
    logic exp_hit;
`ifdef RV_NBLOAD_CAM_BYPASS_EN
    exp_hit = 1'b0;
`else
    exp_hit = 1'b1;
`endif
    do_alloc(5'd4);
    rs1 = 4; wb_valid = 1; wb_tag = 0; #1;
    total++; if (rs1_hit !== exp_hit) begin bad++; $display("FAIL bypass_hit act=%b exp=%b", rs1_hit, exp_hit); end
    step(); wb_valid = 0; #1;
    total++; if (wb_rd_valid !== 1'b1 || wb_rd !== 5'd4) begin bad++; $display("FAIL bypass_wb act=%b/%0d exp=1/4", wb_rd_valid, wb_rd); end
    step();
    do_alloc(5'd4);
    do_alloc(5'd14);
    do_return(2'd0);
    #2 rst_l = 0; #1;
    total++; if (wb_rd_valid !== 1'b0 || wb_rd !== 5'd0) begin bad++; $display("FAIL rst_wb act=%b/%0d exp=0/0", wb_rd_valid, wb_rd); end
    total++; if (count !== 3'd0 || alloc_ready !== 1'b1 || alloc_tag !== 2'd0) begin bad++; $display("FAIL rst_state act=%0d/%b/%0d exp=0/1/0", count, alloc_ready, alloc_tag); end
    rs1 = 14; #1;
    total++; if (rs1_hit !== 1'b0) begin bad++; $display("FAIL rst_hit act=%b exp=0", rs1_hit); end
    rs1 = 0;
    @(negedge clk); rst_l = 1;
    step();
  endtask

  initial begin
    idle_inputs();
    rst_l = 0;
    #12 rst_l = 1;
    step();
    test_reset();
    test_basic();
    test_full();
    test_waw();
    test_flush();
    test_rd0_error();
    test_bypass_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_nbload_cam.md
# lsu_nbload_cam

- Parametrised tracker for outstanding non-blocking loads, placed between decode and the LSU bus interface.
- Each entry holds a valid bit, a write-back-enable bit and a destination register. The entry format is `load_cam_pkt_t` generalised to DEPTH entries.
- The block allocates tags to issuing loads and CAMs source registers for RAW stalls. It suppresses stale write-backs after a WAW overwrite or a pipeline flush, and returns the destination register when data comes back.

## Interface

Parameters:
- DEPTH, 4: number of entries; a power of two in 2..16.
- TAGW, $clog2(DEPTH): tag width; derived, not overridden.

Ports:
- clk  in  1  core clock.
- rst_l  in  1  reset; asynchronous, active-low.
- alloc_valid  in  1  a load issues this cycle.
- alloc_rd  in  5  destination register of the issuing load.
- alloc_ready  out  1  at least one free entry exists.
- alloc_tag  out  TAGW  lowest-index free entry; meaningful only while alloc_ready=1.
- wb_valid  in  1  load data returned this cycle.
- wb_tag  in  TAGW  tag of the returned load.
- wb_error  in  1  returned load faulted; free the entry but do not write back.
- flush  in  1  pipeline flush; every outstanding entry loses its write-back right.
- rs1, rs2  in  5 each  source registers to check.
- rs1_hit, rs2_hit  out  1 each  a pending write-back targets that source.
- wb_rd_valid  out  1  register-file write strobe, registered.
- wb_rd  out  5  register-file write address, registered.
- count  out  TAGW+1  number of valid entries.

## Operation

Allocation:
- Taken when alloc_valid=1 and alloc_ready=1.
- Sets entry[alloc_tag] to valid=1, rd=alloc_rd, wb=(alloc_rd!=0).
- alloc_valid with alloc_ready=0 is ignored; no state changes.
- WAW: in the same cycle, every other valid entry with rd==alloc_rd gets wb=0.

Write-back:
- wb_valid with entry[wb_tag].valid=1 clears that entry.
- The register file is written (wb_rd_valid=1, wb_rd=entry.rd) only when entry.wb=1, wb_error=0 and flush=0.
- wb_valid to an invalid tag is ignored.

Flush:
- Clears wb on every entry that is valid at the start of the cycle. Those entries stay valid until their data returns, so tags are never reused early.
- An allocation in the same cycle as flush is kept, with wb set by the normal rule.

Lookup:
- rsN_hit = (rsN!=0) AND any entry with valid=1 and wb=1 and rd==rsN.
- Combinational on the current state.

Free-slot selection:
- Priority encoder picks the lowest-index invalid entry.
- A slot freed by write-back becomes allocatable the next cycle, not the same cycle.

count: tracks allocations minus frees. A simultaneous allocate and free leaves count unchanged.

## Timing

Reset values:
- All entries valid=0, wb=0, rd=0.
- wb_rd_valid=0, wb_rd=0.
- count=0, alloc_ready=1, alloc_tag=0.

Latency:
- alloc_ready, alloc_tag and rsN_hit are combinational from state.
- A newly allocated entry is visible to lookup the cycle after allocation.
- wb_rd_valid and wb_rd are registered: they assert exactly one cycle after the qualifying wb_valid and hold for one cycle only.

Simultaneous events:
- Allocation of rd X in the same cycle as write-back of an older rd X entry: the older write still proceeds (its wb is sampled before the WAW clear). The younger entry keeps wb=1.
- flush with wb_valid: the write-back is suppressed and the entry is freed.
- Full with a write-back in the same cycle: alloc_ready stays 0 that cycle.

Reset mid-operation: asserting rst_l low clears all state immediately, including a pending registered write-back.

## Configuration

- RV_NBLOAD_CAM_BYPASS_EN defined:
  - rsN_hit is masked in a cycle where wb_valid=1 targets the hitting entry with wb=1, wb_error=0 and flush=0, and no other entry hits.
  - Rationale: the returning data is forwarded in that cycle, so no stall is needed.
- Not defined: the hit stays asserted through the write-back cycle, and consumers stall one extra cycle.

## Test plan

- Reset, then three allocations of rd 5, 6, 7 -> tags 0, 1, 2 and count=3. rs1=6 gives rs1_hit=1 the next cycle. wb_tag=1 gives wb_rd_valid=1, wb_rd=6 one cycle later and rs1_hit=0.
- DEPTH=4: fill all entries -> alloc_ready=0, and a fifth alloc_valid changes nothing. wb_tag=2, then alloc -> tag 2 the cycle after the free.
- Allocate rd 9 (tag 0), then rd 9 again (tag 1). Return tag 0 -> no register write. Return tag 1 -> wb_rd=9.
- Two loads outstanding, flush, then both return -> no wb_rd_valid, count goes 2->0, rs hits are 0 right after the flush.
- Allocate rd 0 -> entry valid and count=1, rs1=0 gives no hit, the return gives no write. wb_error on a rd 3 return -> freed, no write.
- Hit on rd 4 while tag 0 returns in the same cycle -> rs1_hit=0 with RV_NBLOAD_CAM_BYPASS_EN, 1 without. Repeat with rst_l asserted mid-stream -> all outputs return to reset values immediately.
